// File: rtl/fft_sample_deserializer.sv
// ============================================================================
// fft_sample_deserializer
//
// Input stage directly upstream of the FFT. It accepts one BIT_WIDTH real
// sample per recv handshake and collects N_SAMPLES consecutive samples into
// one frame. The frame is then presented as a parallel array on the FFT's
// val/rdy recv interface. The k-th accepted sample of a frame lands in
// send_msg[k]. Bit reversal is left to the FFT.
//
// Configuration macro: FFT_DESER_DOUBLE_BUFFER_EN
//   undefined : single frame buffer with a FILL/FULL FSM. One dead cycle
//               occurs per frame while the full frame is handed over.
//   defined   : ping/pong banks with fill/send bank pointers and a full
//               count. Sustains one sample per cycle when send_rdy is high.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   recv_msg  in   BIT_WIDTH serial input sample
//   recv_val  in   input sample valid
//   recv_rdy  out  input ready (held low while reset is high)
//   send_msg  out  BIT_WIDTH x [N_SAMPLES] frame to the FFT
//   send_val  out  frame valid
//   send_rdy  in   FFT ready
// ============================================================================
module fft_sample_deserializer #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy
);

    localparam int               IDX_W    = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    // wr_idx wraps by natural overflow, so the frame length must be a power of two.
    if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_bad_n_samples
        $error("fft_sample_deserializer: N_SAMPLES must be a power of two >= 2");
    end
    // Samples pass through untouched. The fixed-point position only has to be sane.
    if ((DECIMAL_PT < 0) || (DECIMAL_PT > BIT_WIDTH)) begin : g_bad_decimal_pt
        $error("fft_sample_deserializer: DECIMAL_PT must lie within BIT_WIDTH");
    end

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

`ifdef FFT_DESER_DOUBLE_BUFFER_EN

    logic [BIT_WIDTH-1:0] bank_q [2][N_SAMPLES];
    logic [BIT_WIDTH-1:0] bank_d [2][N_SAMPLES];
    logic                 fill_bank_q, fill_bank_d;
    logic                 send_bank_q, send_bank_d;
    logic [1:0]           full_cnt_q, full_cnt_d;
    logic                 accept, consume, last_accept;

    // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        bank_d      = bank_q;
        wr_idx_d    = wr_idx_q;
        fill_bank_d = fill_bank_q;
        send_bank_d = send_bank_q;
        full_cnt_d  = full_cnt_q;

        accept      = recv_val && recv_rdy;
        consume     = send_val && send_rdy;
        last_accept = accept && (wr_idx_q == LAST_IDX);

        if (accept) begin
            bank_d[fill_bank_q][wr_idx_q] = recv_msg;
            wr_idx_d                      = wr_idx_q + 1'b1;
        end
        if (last_accept) begin
            fill_bank_d = ~fill_bank_q;
        end
        if (consume) begin
            send_bank_d = ~send_bank_q;
        end

        // A completed frame and a consumed frame in the same cycle cancel.
        // Both banks still swap roles.
        case ({last_accept, consume})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    // NOTE: the frame storage is reset on purpose. A reset must leave send_msg at zero
    // and must leave no stale words from a discarded frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q    <= '0;
            fill_bank_q <= 1'b0;
            send_bank_q <= 1'b0;
            full_cnt_q  <= 2'd0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N_SAMPLES; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
        end else begin
            // NOTE: state is updated only with non-blocking assignments, so every flop
            // samples its pre-edge inputs.
            wr_idx_q    <= wr_idx_d;
            fill_bank_q <= fill_bank_d;
            send_bank_q <= send_bank_d;
            full_cnt_q  <= full_cnt_d;
            bank_q      <= bank_d;
        end
    end

    assign recv_rdy = ~reset & (full_cnt_q != 2'd2);
    assign send_val = (full_cnt_q != 2'd0);

    always_comb begin
        for (int k = 0; k < N_SAMPLES; k++) begin
            send_msg[k] = bank_q[send_bank_q][k];
        end
    end

`else

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] mem_q [N_SAMPLES];
    logic [BIT_WIDTH-1:0] mem_d [N_SAMPLES];

    // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        mem_d    = mem_q;

        case (state_q)
            FILL: begin
                if (recv_val) begin
                    mem_d[wr_idx_q] = recv_msg;
                    wr_idx_d        = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (send_rdy) begin
                    state_d  = FILL;
                    wr_idx_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: the frame storage is reset on purpose. A reset must leave send_msg at zero
    // and must leave no stale words from a discarded frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            for (int k = 0; k < N_SAMPLES; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            // NOTE: state is updated only with non-blocking assignments, so every flop
            // samples its pre-edge inputs.
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            mem_q    <= mem_d;
        end
    end

    // Both handshake outputs are decoded straight from the state flop.
    // Neither one depends on the partner's val or rdy.
    assign recv_rdy = ~reset & (state_q == FILL);
    assign send_val = (state_q == FULL);

    always_comb begin
        for (int k = 0; k < N_SAMPLES; k++) begin
            send_msg[k] = mem_q[k];
        end
    end

`endif

endmodule

// File: tb/tb_fft_sample_deserializer.sv
`timescale 1ns/1ps
module tb_fft_sample_deserializer;

    localparam int BW = 32;
    localparam int N  = 8;
`ifdef FFT_DESER_DOUBLE_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [BW-1:0] send_msg [N];
    logic          send_val;
    logic          send_rdy;

    fft_sample_deserializer #(
        .BIT_WIDTH (BW),
        .DECIMAL_PT(16),
        .N_SAMPLES (N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .recv_msg(recv_msg),
        .recv_val(recv_val),
        .recv_rdy(recv_rdy),
        .send_msg(send_msg),
        .send_val(send_val),
        .send_rdy(send_rdy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted samples of the frame in progress, followed by
    // the words of all completed frames that are not yet consumed, oldest first.
    logic [BW-1:0] part_q[$];
    logic [BW-1:0] full_q[$];

    typedef struct {
        logic          val;
        logic [BW-1:0] msg;
        logic          srdy;
        logic          exp_rdy;
        logic          exp_sval;
        bit            chk_frame;
    } vec_t;

    vec_t tbl [N+1];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_rdy();
        return (full_q.size() / N) < CAP;
    endfunction

    function automatic bit exp_val();
        return full_q.size() >= N;
    endfunction

    // Called just after a falling edge. It drives the inputs for one rising
    // edge, advances the model and returns at the next falling edge.
    task automatic tick(input logic v, input logic [BW-1:0] m, input logic r);
        bit acc;
        bit cons;
        recv_val = v;
        recv_msg = m;
        send_rdy = r;
        acc  = v && exp_rdy();
        cons = exp_val() && r;
        @(posedge clk);
        if (cons) begin
            for (int i = 0; i < N; i++) full_q.delete(0);
        end
        if (acc) begin
            part_q.push_back(m);
            if (part_q.size() == N) begin
                for (int i = 0; i < N; i++) full_q.push_back(part_q[i]);
                part_q.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        check({name, "_rdy"}, 32'(recv_rdy), 32'(exp_rdy()));
        check({name, "_val"}, 32'(send_val), 32'(exp_val()));
        if (exp_val()) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("%s_w%0d", name, k), send_msg[k], full_q[k]);
            end
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_rdy"}, 32'(recv_rdy), 32'd0);
        check({name, "_val"}, 32'(send_val), 32'd0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_w%0d", name, k), send_msg[k], '0);
        end
    endtask

    // Called just after a falling edge. Reset is raised and lowered between clock edges.
    task automatic async_reset(input string name);
        #2;
        reset    = 1'b1;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        part_q.delete();
        full_q.delete();
        #1;
        check_zero(name);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check({name, "_rdy_after"}, 32'(recv_rdy), 32'd1);
        check({name, "_val_after"}, 32'(send_val), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] held [N];

        reset    = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        @(negedge clk);
        async_reset("por");

        // 1. Single frame 1..8 with send_rdy high, driven from a vector table.
        for (int i = 0; i < N; i++) begin
            tbl[i].val       = 1'b1;
            tbl[i].msg       = BW'(i + 1);
            tbl[i].srdy      = 1'b1;
            tbl[i].exp_rdy   = (i < N - 1) ? 1'b1 : (CAP == 2);
            tbl[i].exp_sval  = (i == N - 1);
            tbl[i].chk_frame = (i == N - 1);
        end
        tbl[N].val       = 1'b0;
        tbl[N].msg       = '0;
        tbl[N].srdy      = 1'b1;
        tbl[N].exp_rdy   = 1'b1;
        tbl[N].exp_sval  = 1'b0;
        tbl[N].chk_frame = 1'b0;
        for (int i = 0; i <= N; i++) begin
            tick(tbl[i].val, tbl[i].msg, tbl[i].srdy);
            check($sformatf("t1_v%0d_rdy", i), 32'(recv_rdy), 32'(tbl[i].exp_rdy));
            check($sformatf("t1_v%0d_val", i), 32'(send_val), 32'(tbl[i].exp_sval));
            if (tbl[i].chk_frame) begin
                for (int k = 0; k < N; k++) begin
                    check($sformatf("t1_w%0d", k), send_msg[k], BW'(k + 1));
                end
            end
        end

        // 2. Backpressure: the frame is held for 20 cycles, then consumed.
        for (int i = 0; i < N; i++) begin
            tick(1'b1, $urandom, 1'b0);
            check_model("t2_fill");
        end
        for (int k = 0; k < N; k++) held[k] = full_q[k];
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, '0, 1'b0);
            check("t2_hold_val", 32'(send_val), 32'd1);
            check("t2_hold_rdy", 32'(recv_rdy), 32'(CAP == 2));
            for (int k = 0; k < N; k++) check($sformatf("t2_hold_w%0d", k), send_msg[k], held[k]);
        end
        tick(1'b0, '0, 1'b1);
        check("t2_consumed_val", 32'(send_val), 32'd0);
        check("t2_consumed_rdy", 32'(recv_rdy), 32'd1);

        // 3. Gappy input: recv_val alternates, and idle cycles carry junk data.
        for (int j = 0; j < 2 * N; j++) begin
            tick((j % 2) == 0, ((j % 2) == 0) ? BW'(32'h10000 * (j / 2 + 1)) : 32'hDEAD_BEEF, 1'b0);
            check_model("t3");
        end
        for (int k = 0; k < N; k++) check($sformatf("t3_w%0d", k), send_msg[k], BW'(32'h10000 * (k + 1)));
        tick(1'b0, '0, 1'b1);
        check_model("t3_drain");

        // 4. Reset after 5 samples. The next 8 samples must form a clean frame.
        for (int i = 0; i < 5; i++) tick(1'b1, 32'hBAD0_0000 + BW'(i), 1'b1);
        async_reset("t4_rst");
        for (int i = 0; i < N; i++) begin
            tick(1'b1, 32'h100 + BW'(i), 1'b0);
            check_model("t4");
        end
        for (int k = 0; k < N; k++) check($sformatf("t4_w%0d", k), send_msg[k], 32'h100 + BW'(k));
        tick(1'b0, '0, 1'b1);
        check_model("t4_drain");

`ifdef FFT_DESER_DOUBLE_BUFFER_EN
        // 5. Streaming with both sides always ready for three frames.
        for (int t = 1; t <= 3 * N; t++) begin
            tick(1'b1, 32'hC000 + BW'(t), 1'b1);
            check($sformatf("t5_c%0d_rdy", t), 32'(recv_rdy), 32'd1);
            check($sformatf("t5_c%0d_val", t), 32'(send_val), 32'((t % N) == 0));
            check_model("t5");
        end
        tick(1'b0, '0, 1'b1);
        check_model("t5_drain");

        // 6. Two frames are stored under backpressure and then released in order.
        for (int t = 0; t < 2 * N + 2; t++) begin
            tick(1'b1, 32'hD000 + BW'(t), 1'b0);
            check_model("t6_fill");
        end
        check("t6_full_rdy", 32'(recv_rdy), 32'd0);
        tick(1'b0, '0, 1'b1);
        check("t6_b_val", 32'(send_val), 32'd1);
        check("t6_b_rdy", 32'(recv_rdy), 32'd1);
        for (int k = 0; k < N; k++) check($sformatf("t6_b_w%0d", k), send_msg[k], 32'hD000 + BW'(N + k));
        tick(1'b0, '0, 1'b1);
        check("t6_empty_val", 32'(send_val), 32'd0);
`endif

        // Randomised traffic checked against the model, with one reset midway.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) async_reset("rnd_rst");
            tick($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 50);
            check_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
